// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: valid/ready request carrying control and operands,
// valid/ready response carrying result and zero flag.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_ctrl;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU: 1 cycle latency, or shamt+1 for serial shifts (ALU_BARREL_SHIFT_EN gives 1-cycle shifts).
// One op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q;
  logic [XLEN-1:0] res_q;
  logic [SHW-1:0]  cnt_q;
  logic [3:0]      ctrl_q;

  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic [XLEN-1:0] alu_d;
  logic [XLEN-1:0] step_d;
  logic            unused_ctrl;

  assign shamt       = bus.op_b[SHW-1:0];
  assign is_shift    = (bus.alu_ctrl[1:0] == 2'b01);
  assign unused_ctrl = bus.alu_ctrl[4];

  always_comb begin
    alu_d = '0;
    case (bus.alu_ctrl[2:0])
      3'b000: alu_d = bus.alu_ctrl[3] ? (bus.op_a - bus.op_b) : (bus.op_a + bus.op_b);
      3'b010: alu_d = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      3'b011: alu_d = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
      3'b100: alu_d = bus.op_a ^ bus.op_b;
      3'b110: alu_d = bus.op_a | bus.op_b;
      3'b111: alu_d = bus.op_a & bus.op_b;
`ifdef ALU_BARREL_SHIFT_EN
      3'b001: alu_d = bus.op_a << shamt;
      3'b101: alu_d = bus.alu_ctrl[3] ? XLEN'($signed(bus.op_a) >>> shamt) : (bus.op_a >> shamt);
`else
      // Serial shifts start from the raw operand; shamt==0 leaves it as the answer.
      3'b001: alu_d = bus.op_a;
      3'b101: alu_d = bus.op_a;
`endif
      default: alu_d = '0;
    endcase
  end

  // The MSB never moves during a right shift, so it still holds op_a's sign for sra fill.
  always_comb begin
    step_d = '0;
    if (ctrl_q[2:0] == 3'b001) begin
      step_d = {res_q[XLEN-2:0], 1'b0};
    end else if (ctrl_q[3]) begin
      step_d = {res_q[XLEN-1], res_q[XLEN-1:1]};
    end else begin
      step_d = {1'b0, res_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            ctrl_q <= bus.alu_ctrl[3:0];
            res_q  <= alu_d;
            cnt_q  <= shamt;
`ifdef ALU_BARREL_SHIFT_EN
            state_q <= DONE;
`else
            state_q <= (is_shift && (shamt != '0)) ? SHIFT : DONE;
`endif
          end
        end
        SHIFT: begin
          res_q <= step_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == SHW'(1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = (state_q == DONE) && (res_q == '0);
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed ops with literal expectations plus a per-cycle reference model check.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.XLEN(XLEN)) bus();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what the result must be, and how many cycles after accept it appears.
  function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (c[2:0])
      3'd0: begin
        if (c[3]) return a - b;
        return a + b;
      end
      3'd1: return a << sh;
      3'd2: begin
        if ($signed(a) < $signed(b)) return 32'd1;
        return 32'd0;
      end
      3'd3: begin
        if (a < b) return 32'd1;
        return 32'd0;
      end
      3'd4: return a ^ b;
      3'd5: begin
        if (c[3]) return 32'($signed(a) >>> sh);
        return a >> sh;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if (c[1:0] == 2'b01) return int'(b[4:0]) + 1;
    return 1;
`endif
  endfunction

  // Model: 0 = waiting for op, 1 = computing, 2 = result presented.
  int          m_state = 0;
  int          m_wait  = 0;
  logic [31:0] m_res   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (bus.in_valid) begin
          m_res   = ref_alu(bus.alu_ctrl, bus.op_a, bus.op_b);
          m_wait  = ref_lat(bus.alu_ctrl, bus.op_b) - 1;
          m_state = (m_wait == 0) ? 2 : 1;
        end
        1: begin
          m_wait = m_wait - 1;
          if (m_wait == 0) m_state = 2;
        end
        default: if (bus.out_ready) m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", {63'd0, bus.in_ready}, {63'd0, (m_state == 0)});
      check("out_valid", {63'd0, bus.out_valid}, {63'd0, (m_state == 2)});
      check("zero", {63'd0, bus.zero}, {63'd0, (m_state == 2 && m_res == 32'd0)});
      if (m_state == 2) check("result", {32'd0, bus.result}, {32'd0, m_res});
    end
  end

  // Called at a negedge with the unit idle; returns at a negedge after the handshake.
  task automatic do_op(input string name, input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit noisy, input logic [31:0] exp_res, input int ser_lat);
    int lat;
    int exp_lat;
`ifdef ALU_BARREL_SHIFT_EN
    exp_lat = 1;
`else
    exp_lat = ser_lat;
`endif
    bus.in_valid  = 1'b1;
    bus.alu_ctrl  = c;
    bus.op_a      = a;
    bus.op_b      = b;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid  = noisy;
    bus.alu_ctrl  = ~c;
    bus.op_a      = ~a;
    bus.op_b      = b ^ 32'h5;
    bus.out_ready = noisy && (hold == 0);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, {32'd0, bus.result}, {32'd0, exp_res});
    check({name, " zero"}, {63'd0, bus.zero}, {63'd0, (exp_res == 32'd0)});
    repeat (hold) @(negedge clk);
    if (hold > 0) check({name, " held result"}, {32'd0, bus.result}, {32'd0, exp_res});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("reset out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset result", {32'd0, bus.result}, 64'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    do_op("sub", 5'b01000, 32'd5, 32'd7, 0, 1'b0, 32'hFFFF_FFFE, 1);
    do_op("sra neg", 5'b01101, 32'h8000_0000, 32'd4, 0, 1'b0, 32'hF800_0000, 5);
    do_op("slt", 5'b00010, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 32'd1, 1);
    do_op("sltu", 5'b00011, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 32'd0, 1);
    do_op("add wrap hold", 5'b00000, 32'hFFFF_FFFF, 32'd1, 3, 1'b0, 32'd0, 1);
    do_op("sll shamt0", 5'b00001, 32'h1, 32'h20, 0, 1'b0, 32'h1, 1);
    do_op("xor bit4", 5'b10100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1'b1, 32'hFF00_FF00, 1);
    do_op("srl noisy", 5'b00101, 32'h8000_0000, 32'd4, 0, 1'b1, 32'h0800_0000, 5);
    do_op("or", 5'b00110, 32'h1234_0000, 32'h0000_5678, 0, 1'b0, 32'h1234_5678, 1);
    do_op("and", 5'b00111, 32'hFF00_FF00, 32'h0F0F_0F0F, 2, 1'b0, 32'h0F00_0F00, 1);
    do_op("sll 31 noisy", 5'b00001, 32'h1, 32'd31, 0, 1'b1, 32'h8000_0000, 32);
    do_op("sra pos", 5'b01101, 32'h7FFF_FFF0, 32'd3, 0, 1'b0, 32'h0FFF_FFFE, 4);
    do_op("add ovf", 5'b00000, 32'h7FFF_FFFF, 32'd1, 0, 1'b0, 32'h8000_0000, 1);
    do_op("slt neg b", 5'b00010, 32'd1, 32'hFFFF_FFFF, 0, 1'b0, 32'd0, 1);

    // Reset in the middle of a long serial shift.
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 5'b00001;
    bus.op_a     = 32'h1;
    bus.op_b     = 32'd31;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst mid-shift in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst mid-shift out_valid", {63'd0, bus.out_valid}, 64'd0);
    seen = 0;
    repeat (40) @(negedge clk) if (bus.out_valid) seen++;
    check("no result after rst", 64'(seen), 64'd0);

    // Reset wins over an accept in the same cycle.
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 5'b00000;
    bus.op_a     = 32'd2;
    bus.op_b     = 32'd3;
    rst          = 1'b1;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst vs accept in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    check("rst vs accept out_valid", {63'd0, bus.out_valid}, 64'd0);

    // Reset wins over out_ready while a result is presented.
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("done before rst", {63'd0, bus.out_valid}, 64'd1);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    check("rst in done out_valid", {63'd0, bus.out_valid}, 64'd0);
    @(negedge clk);

    do_op("sub after rst", 5'b01000, 32'd10, 32'd10, 0, 1'b0, 32'd0, 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; legal values 32 or 64; SHW = log2(XLEN).
REQ-002 Port: clk  input  1  single clock, all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  unit can accept an operation.
REQ-006 Port: alu_ctrl  input  5  ALU control code {AluOp[1], func7[5], func3[2:0]}; 00000 = add, 01000 = sub.
REQ-007 Port: op_a  input  XLEN  first operand.
REQ-008 Port: op_b  input  XLEN  second operand; op_b[SHW-1:0] is the shift amount.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: result  output  XLEN  operation result.
REQ-012 Port: zero  output  1  high when result == 0, qualified by out_valid.

Function
REQ-013 Op select on alu_ctrl[2:0]: 000 add (sub if alu_ctrl[3]), 001 sll, 010 slt signed, 011 sltu, 100 xor, 101 srl (sra if alu_ctrl[3]), 110 or, 111 and; alu_ctrl[4] has no effect on operation selection.
REQ-014 Add/sub wrap modulo 2^XLEN, no overflow flag; slt/sltu produce 1 or 0 zero-extended.
REQ-015 FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 Accept = in_valid && in_ready; on accept, alu_ctrl, op_a, shift amount are registered; inputs are ignored thereafter until return to IDLE.
REQ-017 Non-shift op: IDLE -> DONE on accept; result valid exactly 1 cycle after accept.
REQ-018 Shift op, shamt = 0: IDLE -> DONE; result = op_a, 1 cycle after accept.
REQ-019 Shift op, shamt = N > 0: IDLE -> SHIFT; one bit position per cycle, remaining count decremented each cycle; SHIFT -> DONE when count reaches 0; out_valid rises N+1 cycles after accept.
REQ-020 sra fills vacated bits with original op_a[XLEN-1]; srl/sll fill with 0.
REQ-021 DONE holds result and zero stable until out_valid && out_ready, then DONE -> IDLE; no accept in the same cycle (min 2 cycles per op).
REQ-022 in_valid while not IDLE has no effect; out_ready while not DONE has no effect.

Reset
REQ-023 rst high at a clock edge forces state IDLE, result 0, shift count 0, out_valid 0, in_ready 1 on the following cycle, from any state.
REQ-024 rst asserted mid-SHIFT or in DONE discards the operation; no result is presented after reset.
REQ-025 rst has priority over accept and over out_ready in the same cycle.

Configuration
REQ-026 Macro ALU_BARREL_SHIFT_EN defined: shifts computed in one cycle via barrel shifter, SHIFT state unused, every op has 1-cycle latency.
REQ-027 Macro ALU_BARREL_SHIFT_EN undefined: serial shifting per REQ-019; results bit-identical to defined case.

Verification
REQ-028 alu_ctrl=01000, op_a=5, op_b=7 -> 1 cycle later out_valid=1, result=0xFFFFFFFE, zero=0.
REQ-029 alu_ctrl=01101, op_a=0x80000000, op_b=4, macro undefined -> out_valid after 5 cycles, result=0xF8000000.
REQ-030 alu_ctrl=00010, op_a=0xFFFFFFFF, op_b=1 -> result=1; alu_ctrl=00011 same operands -> result=0.
REQ-031 alu_ctrl=00000, op_a=0xFFFFFFFF, op_b=1 -> result=0, zero=1; out_ready held low 3 cycles -> result stable, in_ready=0 throughout.
REQ-032 alu_ctrl=00001, op_b=31, rst pulsed at cycle 10 -> next cycle IDLE, in_ready=1, out_valid never asserts for that op.
REQ-033 alu_ctrl=00001, op_a=0x1, op_b=0x20 (shamt 0) -> result=0x1 after 1 cycle in both macro settings.
